fmap_stream_source: RTL and testbench
=====================================

Name: fmap_stream_source

Overview:
- Transmitter-side sequencer for a conv layer's pixel stream. Reads a stored WIDTH x WIDTH feature-map channel from on-chip RAM in raster order and drives it into a layer's control/datapath as a data + valid_in stream.
- Inserts a programmable idle gap after every row except the last, so the downstream line-padding control has cycles to emit padding columns.
- Sits between the inter-layer feature-map buffer and the next layer's control/conv pipeline.

Parameters:
- WIDTH, 5, feature-map width and height in pixels (square map; WIDTH >= 2).
- DATA_W, 16, pixel data width.
- ADDR_W, 10, RAM address width; must satisfy 2^ADDR_W >= base + WIDTH*WIDTH.
- GAP, 2, idle cycles inserted between rows (0 allowed = back-to-back rows).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request to stream one map; sampled only in IDLE.
- base_addr  in  ADDR_W  RAM address of pixel (0,0); latched on an accepted start.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  DATA_W  RAM read data; valid exactly 1 cycle after rd_en.
- data_out  out  DATA_W  pixel to downstream layer.
- valid_out  out  1  data_out is valid; connects to the next layer's valid_in.
- counter_col  out  32  column of the pixel currently on data_out.
- counter_row  out  32  row of the pixel currently on data_out.
- busy  out  1  high while a map is in progress.
- done  out  1  one-cycle pulse when the map is complete.

Behaviour:
- Reset (async, rst=0): state IDLE. rd_en, rd_addr, data_out, valid_out, counter_col, counter_row, busy and done all clear to 0. Internal row/col/gap counters clear to 0. Reset mid-stream aborts immediately; there is no done pulse and no further rd_en.
- All outputs are registered.
- FSM states: IDLE, STREAM, GAP, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr into the issue address, clears issue row/col to 0, sets busy=1, then goes to STREAM.
  - start=0 stays in IDLE.
- STREAM:
  - Each cycle: rd_en=1, rd_addr = issue address; then issue address +1 and col +1.
  - At col = WIDTH-1 (not last row): col wraps to 0, row +1, gap counter loads GAP. Next state is GAP if GAP>0, else STREAM.
  - At col = WIDTH-1 and row = WIDTH-1: next state DRAIN.
- GAP: rd_en=0. Gap counter decrements each cycle; on reaching 1, next state is STREAM.
- DRAIN: rd_en=0. Waits until the last pixel's valid_out has been emitted (2 cycles after its rd_en), then goes to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. done is asserted the cycle after the last valid_out.
- Data path latency: rd_en at cycle t -> rd_data at t+1 -> data_out/valid_out registered at t+2.
  - valid_out is rd_en delayed 2 cycles.
  - counter_col/counter_row are the issue col/row delayed 2 cycles and change only when valid_out=1.
- Address arithmetic: ADDR_W bits, modulo 2^ADDR_W. Overflow is a configuration error and is not checked.
- Issue cycles per map: WIDTH*WIDTH + (WIDTH-1)*GAP. First rd_en is 1 cycle after start is accepted.
- start while busy (any state other than IDLE) is ignored and has no effect on the current map.
- start in the same cycle as done is ignored; the next start is accepted in IDLE the following cycle.
- When valid_out=0, data_out holds its last value (no clearing except on reset).

Test Plan:
- Basic map: WIDTH=5, GAP=2, base=0, RAM returns data=addr, start at cycle 0.
  - Required: 25 valid_out pulses with data 0..24 in order.
  - Required: rd_en high for 5 cycles, low for 2, repeated; last rd_en at cycle 33.
  - Required: last valid_out at cycle 35, done at cycle 36, busy high cycles 1-36.
- GAP=0, WIDTH=4, base=100: valid_out continuous for 16 cycles with data 100..115, and counter_row/col step (0,0)..(3,3).
- Start while busy: pulse start again at cycle 10 with base=500. Required: the stream is identical to the basic-map scenario and exactly one done pulse occurs.
- Reset mid-stream: assert rst=0 at cycle 12. Required: all outputs 0 the same cycle, no done pulse. A new start after release streams a full map from (0,0).
- Back-to-back: start again the cycle after done. Required: second map data correct, and the first rd_en is 1 cycle after that start.
- Counter alignment: at every valid_out, check counter_row*WIDTH + counter_col + base == data_out.

Source files
------------

// File: rtl/fmap_stream_source.sv
// fmap_stream_source
//   Reads one WIDTH x WIDTH feature-map channel from on-chip RAM in raster
//   order and presents it to the next layer as a data + valid stream. After
//   every row except the last, GAP idle cycles are inserted so the downstream
//   line-padding control has room to emit its padding columns.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   start        one-cycle request to stream a map (sampled only in IDLE)
//   base_addr    RAM address of pixel (0,0), latched on an accepted start
//   rd_en        RAM read strobe
//   rd_addr      RAM read address
//   rd_data      RAM read data, valid one cycle after rd_en
//   data_out     pixel to the downstream layer
//   valid_out    data_out carries a pixel this cycle
//   counter_col  column of the pixel on data_out
//   counter_row  row of the pixel on data_out
//   busy         high while a map is in progress
//   done         one-cycle pulse the cycle after the last valid_out
//
// Stream handshake: valid-only, no backpressure. A pixel is transferred in
// every cycle where valid_out=1; the consumer must accept it in that cycle.
// data_out and the counters hold their last values while valid_out=0.

module fmap_stream_source #(
    parameter int WIDTH  = 5,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int GAP    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [31:0]       counter_col,
    output logic [31:0]       counter_row,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_GAP    = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t state;

    // Issue position: row/col of the read being strobed this cycle.
    logic [31:0] col;
    logic [31:0] row;
    logic [31:0] gap_cnt;

    // Stage 1 of the read pipeline (cycle in which rd_data is valid).
    logic        p_valid;
    logic [31:0] p_col;
    logic [31:0] p_row;

    // Control FSM. The registered read strobe/address are set on the edge
    // that enters a read cycle, so rd_en is high in exactly the cycles the
    // FSM is in S_STREAM and the first read follows start by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            col     <= '0;
            row     <= '0;
            gap_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_STREAM;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= base_addr;
                        col     <= '0;
                        row     <= '0;
                    end
                end
                S_STREAM: begin
                    if (col == 32'(WIDTH - 1)) begin
                        col <= '0;
                        if (row == 32'(WIDTH - 1)) begin
                            rd_en <= 1'b0;
                            state <= S_DRAIN;
                        end else begin
                            row <= row + 32'd1;
                            if (GAP > 0) begin
                                rd_en   <= 1'b0;
                                gap_cnt <= 32'(GAP);
                                state   <= S_GAP;
                            end else begin
                                rd_addr <= rd_addr + ADDR_W'(1);
                            end
                        end
                    end else begin
                        col     <= col + 32'd1;
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                S_GAP: begin
                    // rd_addr still points at the last pixel of the previous
                    // row, so the next row resumes at rd_addr + 1.
                    if (gap_cnt == 32'd1) begin
                        gap_cnt <= '0;
                        rd_en   <= 1'b1;
                        rd_addr <= rd_addr + ADDR_W'(1);
                        state   <= S_STREAM;
                    end else begin
                        gap_cnt <= gap_cnt - 32'd1;
                    end
                end
                S_DRAIN: begin
                    // Once stage 1 is empty the last pixel is on valid_out
                    // this cycle, so done lands in the following cycle.
                    if (!p_valid) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Two-stage read pipeline: rd_en at t, rd_data at t+1, outputs at t+2.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_valid     <= 1'b0;
            p_col       <= '0;
            p_row       <= '0;
            valid_out   <= 1'b0;
            data_out    <= '0;
            counter_col <= '0;
            counter_row <= '0;
        end else begin
            p_valid   <= rd_en;
            p_col     <= col;
            p_row     <= row;
            valid_out <= p_valid;
            if (p_valid) begin
                data_out    <= rd_data;
                counter_col <= p_col;
                counter_row <= p_row;
            end
        end
    end

endmodule

// File: tb/tb_fmap_stream_source.sv
module tb_fmap_stream_source;

    localparam int W_A = 5;
    localparam int G_A = 2;
    localparam int W_B = 4;
    localparam int G_B = 0;
    localparam int DW  = 16;
    localparam int AW  = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // ---------------- DUT A: WIDTH=5, GAP=2 ----------------
    logic          start_a;
    logic [AW-1:0] base_a;
    logic          rd_en_a;
    logic [AW-1:0] rd_addr_a;
    logic [DW-1:0] rd_data_a;
    logic [DW-1:0] data_out_a;
    logic          valid_out_a;
    logic [31:0]   col_a;
    logic [31:0]   row_a;
    logic          busy_a;
    logic          done_a;

    fmap_stream_source #(.WIDTH(W_A), .DATA_W(DW), .ADDR_W(AW), .GAP(G_A)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .base_addr(base_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .data_out(data_out_a), .valid_out(valid_out_a),
        .counter_col(col_a), .counter_row(row_a),
        .busy(busy_a), .done(done_a)
    );

    // ---------------- DUT B: WIDTH=4, GAP=0 ----------------
    logic          start_b;
    logic [AW-1:0] base_b;
    logic          rd_en_b;
    logic [AW-1:0] rd_addr_b;
    logic [DW-1:0] rd_data_b;
    logic [DW-1:0] data_out_b;
    logic          valid_out_b;
    logic [31:0]   col_b;
    logic [31:0]   row_b;
    logic          busy_b;
    logic          done_b;

    fmap_stream_source #(.WIDTH(W_B), .DATA_W(DW), .ADDR_W(AW), .GAP(G_B)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .data_out(data_out_b), .valid_out(valid_out_b),
        .counter_col(col_b), .counter_row(row_b),
        .busy(busy_b), .done(done_b)
    );

    // RAM models: one-cycle read latency, data = address.
    always @(posedge clk) begin
        if (rd_en_a) rd_data_a <= {6'b0, rd_addr_a};
        if (rd_en_b) rd_data_b <= {6'b0, rd_addr_b};
    end

    // ---------------- scoreboard ----------------
    // Entry: {row[7:0], col[7:0], data[15:0]}
    logic [31:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic push_map(input int w, input logic [AW-1:0] base);
        logic [AW-1:0] a;
        for (int r = 0; r < w; r++) begin
            for (int c = 0; c < w; c++) begin
                a = base + AW'(r * w + c);
                exp_q.push_back({8'(r), 8'(c), 6'b0, a});
            end
        end
    endtask

    // Reference rd_en pattern for DUT A, cycle 1 = first cycle after start.
    function automatic bit exp_rd_a(input int c);
        return (c >= 1) && (c <= W_A * W_A + (W_A - 1) * G_A) && (((c - 1) % (W_A + G_A)) < W_A);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        start_a = 1'b0; base_a = '0;
        start_b = 1'b0; base_b = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({rd_en_a, rd_addr_a, data_out_a, valid_out_a, col_a, row_a, busy_a, done_a} !== '0) begin
            n_fail++;
            $display("FAIL reset_a: got %h required 0",
                     {rd_en_a, rd_addr_a, data_out_a, valid_out_a, col_a, row_a, busy_a, done_a});
        end
        n_tests++;
        if ({rd_en_b, rd_addr_b, data_out_b, valid_out_b, col_b, row_b, busy_b, done_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_b: got %h required 0",
                     {rd_en_b, rd_addr_b, data_out_b, valid_out_b, col_b, row_b, busy_b, done_b});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    // Full map on DUT A with base 0; optionally a second start at cycle 10.
    task automatic test_basic_map(input bit busy_start);
        int issued, done_cnt, last_valid;
        logic [31:0] e;
        exp_q.delete();
        push_map(W_A, '0);
        base_a = '0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        issued = 0; done_cnt = 0; last_valid = -1;
        for (int cyc = 1; cyc <= 45; cyc++) begin
            n_tests++;
            if (rd_en_a !== exp_rd_a(cyc)) begin
                n_fail++;
                $display("FAIL basic_rd_en cyc %0d: got %b required %b", cyc, rd_en_a, exp_rd_a(cyc));
            end
            if (exp_rd_a(cyc)) begin
                n_tests++;
                if (rd_addr_a !== AW'(issued)) begin
                    n_fail++;
                    $display("FAIL basic_rd_addr cyc %0d: got %0d required %0d", cyc, rd_addr_a, issued);
                end
                issued++;
            end
            n_tests++;
            if (busy_a !== (cyc >= 1 && cyc <= 36)) begin
                n_fail++;
                $display("FAIL basic_busy cyc %0d: got %b required %b", cyc, busy_a, (cyc >= 1 && cyc <= 36));
            end
            n_tests++;
            if (done_a !== (cyc == 36)) begin
                n_fail++;
                $display("FAIL basic_done cyc %0d: got %b required %b", cyc, done_a, (cyc == 36));
            end
            n_tests++;
            if (valid_out_a !== exp_rd_a(cyc - 2)) begin
                n_fail++;
                $display("FAIL basic_valid cyc %0d: got %b required %b", cyc, valid_out_a, exp_rd_a(cyc - 2));
            end
            if (valid_out_a === 1'b1) begin
                last_valid = cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL basic_extra_valid cyc %0d: got data %0d required no pixel", cyc, data_out_a);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out_a !== e[15:0]) begin
                        n_fail++;
                        $display("FAIL basic_data cyc %0d: got %0d required %0d", cyc, data_out_a, e[15:0]);
                    end
                    n_tests++;
                    if ({row_a, col_a} !== {24'b0, e[31:24], 24'b0, e[23:16]}) begin
                        n_fail++;
                        $display("FAIL basic_counters cyc %0d: got (%0d,%0d) required (%0d,%0d)",
                                 cyc, row_a, col_a, e[31:24], e[23:16]);
                    end
                    n_tests++;
                    if (row_a * W_A + col_a !== {16'b0, data_out_a}) begin
                        n_fail++;
                        $display("FAIL basic_align cyc %0d: got row*W+col %0d required data %0d",
                                 cyc, row_a * W_A + col_a, data_out_a);
                    end
                end
            end
            if (done_a === 1'b1) done_cnt++;
            if (busy_start && cyc == 10) begin
                base_a  = 10'd500;
                start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            @(negedge clk);
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL basic_missing: got %0d pixels left required 0", exp_q.size());
        end
        n_tests++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL basic_done_count: got %0d required 1", done_cnt);
        end
        n_tests++;
        if (last_valid != 35) begin
            n_fail++;
            $display("FAIL basic_last_valid: got %0d required 35", last_valid);
        end
    endtask

    // DUT B: GAP=0, WIDTH=4, base 100 -> continuous 16-pixel stream.
    task automatic test_gap0();
        int issued, done_cnt;
        logic [31:0] e;
        exp_q.delete();
        push_map(W_B, 10'd100);
        base_b = 10'd100;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        issued = 0; done_cnt = 0;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            n_tests++;
            if (rd_en_b !== (cyc >= 1 && cyc <= 16)) begin
                n_fail++;
                $display("FAIL gap0_rd_en cyc %0d: got %b required %b", cyc, rd_en_b, (cyc >= 1 && cyc <= 16));
            end
            if (cyc >= 1 && cyc <= 16) begin
                n_tests++;
                if (rd_addr_b !== AW'(100 + issued)) begin
                    n_fail++;
                    $display("FAIL gap0_rd_addr cyc %0d: got %0d required %0d", cyc, rd_addr_b, 100 + issued);
                end
                issued++;
            end
            n_tests++;
            if (valid_out_b !== (cyc >= 3 && cyc <= 18)) begin
                n_fail++;
                $display("FAIL gap0_valid cyc %0d: got %b required %b", cyc, valid_out_b, (cyc >= 3 && cyc <= 18));
            end
            n_tests++;
            if ({busy_b, done_b} !== {(cyc >= 1 && cyc <= 19), (cyc == 19)}) begin
                n_fail++;
                $display("FAIL gap0_busy_done cyc %0d: got %b%b required %b%b", cyc, busy_b, done_b,
                         (cyc >= 1 && cyc <= 19), (cyc == 19));
            end
            if (valid_out_b === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL gap0_extra_valid cyc %0d: got data %0d required no pixel", cyc, data_out_b);
                end else begin
                    e = exp_q.pop_front();
                    if (data_out_b !== e[15:0]) begin
                        n_fail++;
                        $display("FAIL gap0_data cyc %0d: got %0d required %0d", cyc, data_out_b, e[15:0]);
                    end
                    n_tests++;
                    if ({row_b, col_b} !== {24'b0, e[31:24], 24'b0, e[23:16]}) begin
                        n_fail++;
                        $display("FAIL gap0_counters cyc %0d: got (%0d,%0d) required (%0d,%0d)",
                                 cyc, row_b, col_b, e[31:24], e[23:16]);
                    end
                    n_tests++;
                    if (row_b * W_B + col_b + 32'd100 !== {16'b0, data_out_b}) begin
                        n_fail++;
                        $display("FAIL gap0_align cyc %0d: got row*W+col+base %0d required data %0d",
                                 cyc, row_b * W_B + col_b + 32'd100, data_out_b);
                    end
                end
            end
            if (done_b === 1'b1) done_cnt++;
            @(negedge clk);
        end
        n_tests++;
        if (exp_q.size() != 0 || done_cnt != 1) begin
            n_fail++;
            $display("FAIL gap0_end: got %0d left, %0d done required 0 left, 1 done", exp_q.size(), done_cnt);
        end
    endtask

    // Reset asserted at cycle 12 of a map, then a fresh map after release.
    task automatic test_reset_mid();
        int bad;
        base_a = '0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int cyc = 1; cyc < 12; cyc++) @(negedge clk);
        n_tests++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_busy_before: got %b required 1", busy_a);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({rd_en_a, rd_addr_a, data_out_a, valid_out_a, col_a, row_a, busy_a, done_a} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h required 0",
                     {rd_en_a, rd_addr_a, data_out_a, valid_out_a, col_a, row_a, busy_a, done_a});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done_a !== 1'b0 || rd_en_a !== 1'b0 || valid_out_a !== 1'b0 || busy_a !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got %0d active cycles required 0", bad);
        end
        test_basic_map(1'b0);
    endtask

    // Start held through the done cycle and the next: only the second is taken.
    task automatic test_back_to_back();
        int issued, done_cnt;
        logic [31:0] e;
        logic exp_rd, exp_v;
        exp_q.delete();
        push_map(W_A, '0);
        push_map(W_A, 10'd200);
        base_a = '0;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        issued = 0; done_cnt = 0;
        for (int cyc = 1; cyc <= 82; cyc++) begin
            exp_rd = exp_rd_a(cyc) || exp_rd_a(cyc - 37);
            exp_v  = exp_rd_a(cyc - 2) || exp_rd_a(cyc - 39);
            n_tests++;
            if (rd_en_a !== exp_rd) begin
                n_fail++;
                $display("FAIL b2b_rd_en cyc %0d: got %b required %b", cyc, rd_en_a, exp_rd);
            end
            if (exp_rd) begin
                n_tests++;
                if (rd_addr_a !== ((issued < 25) ? AW'(issued) : AW'(200 + issued - 25))) begin
                    n_fail++;
                    $display("FAIL b2b_rd_addr cyc %0d: got %0d required %0d", cyc, rd_addr_a,
                             (issued < 25) ? issued : 200 + issued - 25);
                end
                issued++;
            end
            n_tests++;
            if ({busy_a, done_a} !== {((cyc >= 1 && cyc <= 36) || (cyc >= 38 && cyc <= 73)),
                                      (cyc == 36 || cyc == 73)}) begin
                n_fail++;
                $display("FAIL b2b_busy_done cyc %0d: got %b%b", cyc, busy_a, done_a);
            end
            n_tests++;
            if (valid_out_a !== exp_v) begin
                n_fail++;
                $display("FAIL b2b_valid cyc %0d: got %b required %b", cyc, valid_out_a, exp_v);
            end
            if (valid_out_a === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL b2b_extra_valid cyc %0d: got data %0d required no pixel", cyc, data_out_a);
                end else begin
                    e = exp_q.pop_front();
                    if ({row_a[7:0], col_a[7:0], data_out_a} !== e) begin
                        n_fail++;
                        $display("FAIL b2b_pixel cyc %0d: got (%0d,%0d) %0d required (%0d,%0d) %0d",
                                 cyc, row_a, col_a, data_out_a, e[31:24], e[23:16], e[15:0]);
                    end
                end
            end
            if (done_a === 1'b1) done_cnt++;
            if (cyc == 36 || cyc == 37) begin
                base_a  = 10'd200;
                start_a = 1'b1;
            end else begin
                start_a = 1'b0;
            end
            @(negedge clk);
        end
        n_tests++;
        if (exp_q.size() != 0 || done_cnt != 2) begin
            n_fail++;
            $display("FAIL b2b_end: got %0d left, %0d done required 0 left, 2 done", exp_q.size(), done_cnt);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic_map(1'b0);
        test_basic_map(1'b1);
        test_gap0();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
